// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI master that reads a 12-bit serial ADC (16-clock frame) at a fixed sample rate.
// Build option ADC_AVG_EN: report the truncated mean of every 4 accepted samples instead of each one.
module adc_spi_reader #(
  parameter int unsigned SCLK_DIV      = 5,
  parameter int unsigned SAMPLE_PERIOD = 200,
  parameter int unsigned LEAD_ZEROS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] adc_data,
  output logic        adc_valid,
  output logic        frame_err,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic        busy
);
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned TMR_W      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned CNT_W      = $clog2(2 * SCLK_DIV);
  localparam int unsigned EDGE_W     = $clog2(FRAME_BITS + 1);
  localparam logic [FRAME_BITS-1:0] LEAD_MASK =
    FRAME_BITS'(((32'd1 << LEAD_ZEROS) - 32'd1) << (FRAME_BITS - LEAD_ZEROS));

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} state_t;

  state_t                  state_q;
  logic [TMR_W-1:0]        tmr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [EDGE_W-1:0]       edge_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic                    tick;
  logic                    lead_ok;

  assign tick    = (tmr_q == TMR_W'(SAMPLE_PERIOD - 1));
  assign lead_ok = ((shift_q & LEAD_MASK) == '0);

`ifdef ADC_AVG_EN
  localparam int unsigned SUM_W = DATA_W + 2;
  logic [SUM_W-1:0] sum_q;
  logic [1:0]       avg_cnt_q;
  logic [SUM_W-1:0] sum_next;
  assign sum_next = sum_q + SUM_W'(shift_q[DATA_W-1:0]);
`endif

  // Free-running sample timer, independent of enable and of the frame FSM
  always_ff @(posedge clk) begin
    if (rst || tick) tmr_q <= '0;
    else             tmr_q <= tmr_q + TMR_W'(1);
  end

  // Frame sequencer: IDLE -> SETUP -> SHIFT (16 SCLK periods) -> HOLD -> QUIET -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      shift_q   <= '0;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b1;
      adc_data  <= '0;
      adc_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef ADC_AVG_EN
      sum_q     <= '0;
      avg_cnt_q <= '0;
`endif
    end else begin
      adc_valid <= 1'b0;
      frame_err <= 1'b0;
      if (tick && (state_q != IDLE)) overrun <= 1'b1;
      else if (overrun_clr)          overrun <= 1'b0;

      case (state_q)
        IDLE: begin
          if (tick && enable) begin
            state_q  <= SETUP;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
            cnt_q    <= '0;
          end
        end
        SETUP: begin
          if (cnt_q == CNT_W'(SCLK_DIV - 1)) begin
            cnt_q    <= '0;
            edge_q   <= '0;
            adc_sclk <= 1'b0;
            state_q  <= SHIFT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_W'(SCLK_DIV - 1)) begin
            cnt_q <= '0;
            if (!adc_sclk) begin
              // MISO is captured on the same edge that raises SCLK
              adc_sclk <= 1'b1;
              shift_q  <= {shift_q[FRAME_BITS-2:0], adc_miso};
              edge_q   <= edge_q + EDGE_W'(1);
            end else if (edge_q == EDGE_W'(FRAME_BITS)) begin
              state_q <= HOLD;
            end else begin
              adc_sclk <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_q == CNT_W'(SCLK_DIV - 1)) begin
            cnt_q    <= '0;
            adc_cs_n <= 1'b1;
            state_q  <= QUIET;
            if (lead_ok) begin
`ifdef ADC_AVG_EN
              if (avg_cnt_q == 2'd3) begin
                adc_data  <= sum_next[SUM_W-1:2];
                adc_valid <= 1'b1;
                sum_q     <= '0;
                avg_cnt_q <= '0;
              end else begin
                sum_q     <= sum_next;
                avg_cnt_q <= avg_cnt_q + 2'd1;
              end
`else
              adc_data  <= shift_q[DATA_W-1:0];
              adc_valid <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        QUIET: begin
          if (cnt_q == CNT_W'(2 * SCLK_DIV - 1)) begin
            cnt_q   <= '0;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: scoreboard bench for adc_spi_reader with a serial ADC model and a
// sample-level reference; a second instance runs with a short sample period to exercise overrun.
`timescale 1ns/1ps
module tb_adc_spi_reader;
  localparam int D    = 5;
  localparam int SP   = 200;
  localparam int SP_B = 150;
  localparam int LAT  = 34 * D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: nominal sample period
  logic        rst, enable, adc_miso, overrun_clr;
  logic        adc_cs_n, adc_sclk, adc_valid, frame_err, overrun, busy;
  logic [11:0] adc_data;

  adc_spi_reader #(.SCLK_DIV(D), .SAMPLE_PERIOD(SP), .LEAD_ZEROS(4)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_miso(adc_miso),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_data(adc_data),
    .adc_valid(adc_valid), .frame_err(frame_err), .overrun(overrun),
    .overrun_clr(overrun_clr), .busy(busy)
  );

  // Instance B: sample period shorter than one frame, ADC always returns 0
  logic        rst_b, enable_b, miso_b, clr_b;
  logic        cs_n_b, sclk_b, valid_b, err_b, overrun_b, busy_b;
  logic [11:0] data_b;

  adc_spi_reader #(.SCLK_DIV(D), .SAMPLE_PERIOD(SP_B), .LEAD_ZEROS(4)) u_dut_b (
    .clk(clk), .rst(rst_b), .enable(enable_b), .adc_miso(miso_b),
    .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .adc_data(data_b),
    .adc_valid(valid_b), .frame_err(err_b), .overrun(overrun_b),
    .overrun_clr(clr_b), .busy(busy_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model and scoreboard for instance A ----------------
  typedef struct { bit err; int data; int when; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] word_q[$];
  logic [15:0] cur_word = 16'h0;
  int          fall_idx = 0;
  int          rises = 0;
  int          n_falls = 0;
  int          cs_fall_cyc = 0;
  bit          abort = 1'b1;
  logic        cs_prev = 1'b1;
  int          model_data = 0;
`ifdef ADC_AVG_EN
  int          acc_sum = 0;
  int          acc_n = 0;
`endif

  function automatic logic [15:0] rand_good();
    return {4'h0, 12'($urandom)};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [3:0] lead = 4'h0;
    if ($urandom_range(3) == 0) lead = 4'($urandom_range(15, 1));
    return {lead, 12'($urandom)};
  endfunction

  task automatic predict(input logic [15:0] w, input int when);
    exp_t e;
    if (w[15:12] != 4'h0) begin
      e = '{1'b1, model_data, when};
      exp_q.push_back(e);
    end else begin
`ifdef ADC_AVG_EN
      acc_sum += int'(w[11:0]);
      acc_n++;
      if (acc_n == 4) begin
        model_data = acc_sum / 4;
        e = '{1'b0, model_data, when};
        exp_q.push_back(e);
        acc_sum = 0;
        acc_n = 0;
      end
`else
      model_data = int'(w[11:0]);
      e = '{1'b0, model_data, when};
      exp_q.push_back(e);
`endif
    end
  endtask

  // ADC model: one new word per frame, next bit presented on every SCLK falling edge
  always @(negedge adc_sclk) begin
    if (!adc_cs_n && fall_idx < 16) begin
      adc_miso = cur_word[4'(15 - fall_idx)];
      fall_idx++;
    end
  end

  always @(posedge adc_sclk) if (adc_cs_n === 1'b0) rises++;

  // Frame start: pick the word and predict the strobe; frame end: check SCLK count and CS width
  always @(negedge clk) begin
    if (cs_prev && (adc_cs_n === 1'b0)) begin
      n_falls++;
      cs_fall_cyc = cyc;
      rises = 0;
      abort = 1'b0;
      if (word_q.size() > 0) cur_word = word_q.pop_front();
      else                   cur_word = rand_good();
      fall_idx = 0;
      adc_miso = cur_word[15];
      if (!rst) predict(cur_word, cyc + LAT);
      else      abort = 1'b1;
    end else if (!cs_prev && (adc_cs_n === 1'b1) && !abort) begin
      check("sclk_rising_edges", rises, 16);
      check("cs_low_cycles", cyc - cs_fall_cyc, LAT);
    end
    cs_prev = (adc_cs_n !== 1'b0);
  end

  // Monitor: every strobe pops one expectation and checks kind, data and timing
  always @(negedge clk) begin
    exp_t e;
    if ((adc_valid === 1'b1) || (frame_err === 1'b1)) begin
      check("strobe_exclusive", int'(adc_valid & frame_err), 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: valid=%0d err=%0d data=%0d with nothing expected (cycle %0d)",
                 adc_valid, frame_err, adc_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind_err", int'(frame_err), int'(e.err));
        check("strobe_data", int'(adc_data), e.data);
        check("strobe_cycle", cyc, e.when);
      end
    end
  end

  // ---------------- instance B monitor ----------------
  int   nb_falls = 0;
  int   fb_cyc = 0;
  logic cs_prev_b = 1'b1;
  bit   b_done = 1'b0;

  always @(negedge clk) begin
    if (cs_prev_b && (cs_n_b === 1'b0)) begin
      nb_falls++;
      fb_cyc = cyc;
    end
    cs_prev_b = (cs_n_b !== 1'b0);
    if (valid_b === 1'b1) check("b_data", int'(data_b), 0);
    if (err_b === 1'b1)   check("b_frame_err", int'(err_b), 0);
  end

  // ---------------- helpers ----------------
  task automatic wait_falls(input int target, input int budget, input string name);
    int t = 0;
    while (n_falls < target && t < budget) begin @(negedge clk); t++; end
    check(name, (n_falls >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_b(input int target, input int budget, input string name);
    int t = 0;
    while (nb_falls < target && t < budget) begin @(negedge clk); t++; end
    check(name, (nb_falls >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin @(negedge clk); t++; end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    abort = 1'b1;
    exp_q.delete();
    model_data = 0;
`ifdef ADC_AVG_EN
    acc_sum = 0;
    acc_n = 0;
`endif
    @(negedge clk);
    check({tag, "_cs_n"},      int'(adc_cs_n), 1);
    check({tag, "_sclk"},      int'(adc_sclk), 1);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_valid"},     int'(adc_valid), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_overrun"},   int'(overrun), 0);
    check({tag, "_data"},      int'(adc_data), 0);
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- instance A stimulus ----------------
  initial begin : main
    int f0;
    int c_prev;
    int t;
    rst = 1'b1; enable = 1'b0; adc_miso = 1'b0; overrun_clr = 1'b0;
    rst_b = 1'b1; enable_b = 1'b1; miso_b = 1'b0; clr_b = 1'b0;

    word_q.push_back(16'h0708);
    enable = 1'b1;
    do_reset("rst_init");
    check("rst_b_overrun", int'(overrun_b), 0);
    check("rst_b_busy",    int'(busy_b), 0);
    check("rst_b_sclk",    int'(sclk_b), 1);
    rst_b = 1'b0;

    // Good frame 1800, then a frame with a bad leading nibble
    wait_falls(1, SP + 5, "first_frame_start");
    c_prev = cs_fall_cyc;
    word_q.push_back(16'h8800);
    wait_falls(2, SP + 5, "second_frame_start");
    check("cs_fall_interval", cs_fall_cyc - c_prev, SP);
    wait_drain(LAT + 5, "err_frame_drain");
`ifndef ADC_AVG_EN
    check("data_hold_after_err", int'(adc_data), 1800);
`endif

    // Randomized words, about a quarter with corrupted leading bits
    for (int i = 0; i < 16; i++) word_q.push_back(rand_word());
    f0 = n_falls;
    wait_falls(f0 + 16, 17 * SP, "random_frames");

    // Reset during the 8th SCLK period
    wait_falls(f0 + 17, SP + 5, "reset_frame_start");
    t = 0;
    while (rises < 7 && t < LAT) begin @(negedge clk); t++; end
    check("reached_8th_period", (rises >= 7) ? 1 : 0, 1);
    repeat (6) @(negedge clk);
    do_reset("rst_mid");
    word_q.push_back(16'h0800);
    f0 = n_falls;
    wait_falls(f0 + 1, SP + 5, "post_reset_frame");
    wait_drain(LAT + 5, "post_reset_drain");
`ifndef ADC_AVG_EN
    check("post_reset_data", int'(adc_data), 2048);
`endif

    // Drop enable mid-SHIFT: frame completes, then no frames for 5 periods
    word_q.push_back(16'd2200);
    f0 = n_falls;
    wait_falls(f0 + 1, SP + 5, "enable_drop_frame");
    repeat (40) @(negedge clk);
    enable = 1'b0;
    wait_drain(LAT, "enable_drop_drain");
`ifndef ADC_AVG_EN
    check("enable_drop_data", int'(adc_data), 2200);
`endif
    f0 = n_falls;
    repeat (5 * SP) @(negedge clk);
    check("no_frames_while_disabled", n_falls - f0, 0);

    // Clean accumulator, then the averaging sequence
    do_reset("rst_idle");
    word_q.push_back(16'd2040);
    word_q.push_back(16'd2044);
    word_q.push_back(16'h8000);
    word_q.push_back(16'd2048);
    word_q.push_back(16'd2060);
    enable = 1'b1;
    f0 = n_falls;
    wait_falls(f0 + 1, SP + 5, "resume_after_enable");
    wait_falls(f0 + 5, 5 * SP, "avg_seq_frames");
    wait_drain(LAT + 5, "avg_seq_drain");
`ifdef ADC_AVG_EN
    check("avg_seq_data", int'(adc_data), 2048);
`else
    check("avg_seq_data", int'(adc_data), 2060);
`endif

    enable = 1'b0;
    wait_drain(SP + 5, "final_drain");
    check("a_overrun_never", int'(overrun), 0);

    t = 0;
    while (!b_done && t < 20 * SP) begin @(negedge clk); t++; end
    check("b_sequence_done", int'(b_done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- instance B stimulus: overrun behaviour ----------------
  initial begin : ovr
    int c1, c2, c3;
    @(negedge clk);
    while (rst_b) @(negedge clk);

    wait_b(1, SP_B + 5, "b_frame1");
    c1 = fb_cyc;
    wait_cyc(c1 + SP_B - 1);
    check("b_overrun_before_busy_tick", int'(overrun_b), 0);
    wait_cyc(c1 + SP_B);
    check("b_overrun_set", int'(overrun_b), 1);

    wait_b(2, 2 * SP_B + 5, "b_frame2");
    c2 = fb_cyc;
    check("b_frame_interval", c2 - c1, 2 * SP_B);
    wait_cyc(c2 + 10);
    clr_b = 1'b1;
    wait_cyc(c2 + 11);
    clr_b = 1'b0;
    check("b_overrun_cleared", int'(overrun_b), 0);
    wait_cyc(c2 + SP_B - 1);
    check("b_overrun_stays_clear", int'(overrun_b), 0);
    wait_cyc(c2 + SP_B);
    check("b_overrun_set_again", int'(overrun_b), 1);

    wait_b(3, 2 * SP_B + 5, "b_frame3");
    c3 = fb_cyc;
    wait_cyc(c3 + 10);
    clr_b = 1'b1;
    wait_cyc(c3 + 11);
    clr_b = 1'b0;
    check("b_overrun_cleared2", int'(overrun_b), 0);
    wait_cyc(c3 + SP_B - 1);
    clr_b = 1'b1;
    wait_cyc(c3 + SP_B);
    clr_b = 1'b0;
    check("b_set_beats_clear", int'(overrun_b), 1);
    b_done = 1'b1;
  end
endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- SPI master that reads a 12-bit serial ADC (16-clock frame: 4 leading zeros, then 12 data bits MSB first) at a fixed sample rate.
- Presents each result as `adc_data` plus a one-cycle `adc_valid` strobe. These are exactly the signals `buck_converter_top` consumes on its ADC input.
- Sits between the board ADC pins and the buck controller and replaces the bench-driven ADC stimulus in hardware builds.

Parameters:
- `SCLK_DIV`, default 5: clk cycles per SCLK half-period (D). Must be ≥ 2. 10 MHz SCLK at 100 MHz clk.
- `SAMPLE_PERIOD`, default 200: clk cycles between sample ticks. 500 kSPS at 100 MHz.
- `LEAD_ZEROS`, default 4: number of leading frame bits that must read 0.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: allows new conversions to start.
- `adc_miso` input 1: serial data from the ADC.
- `adc_cs_n` output 1: ADC chip select, active low.
- `adc_sclk` output 1: SPI clock, idles high.
- `adc_data` output 12: last accepted sample.
- `adc_valid` output 1: one-cycle strobe, high when `adc_data` is updated.
- `frame_err` output 1: one-cycle strobe, high when a leading-zero check fails.
- `overrun` output 1: sticky flag, set when a sample tick arrives while a frame is busy.
- `overrun_clr` input 1: clears `overrun`.
- `busy` output 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: `adc_cs_n`=1, `adc_sclk`=1, `adc_data`=0, `adc_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. The sample timer and all counters clear to 0.
- Sample timer:
  - Free-running 0..`SAMPLE_PERIOD`-1. A tick is asserted when the count equals `SAMPLE_PERIOD`-1.
  - The timer runs whether or not `enable` is high.
- Tick handling:
  - Tick in IDLE with `enable`=1: the FSM starts a frame.
  - Tick in any other state: sets `overrun` and is otherwise dropped.
  - Tick in IDLE with `enable`=0: ignored.
- FSM states: IDLE, SETUP, SHIFT, HOLD, QUIET.
  - IDLE → SETUP on an accepted tick. `adc_cs_n` falls on that clock edge (1 cycle after the tick).
  - SETUP: lasts D cycles with `adc_sclk` held high, then → SHIFT.
  - SHIFT: runs 16 SCLK periods, each D cycles low followed by D cycles high.
    - `adc_miso` is sampled on the same clk edge that drives `adc_sclk` 0→1, and shifted into a 16-bit register MSB first.
    - After the 16th rising edge, SHIFT → HOLD.
  - HOLD: D cycles with `adc_sclk` high and `adc_cs_n` low. On the edge that raises `adc_cs_n`:
    - If bits [15:12] of the frame are all 0: `adc_data` ← bits [11:0] and `adc_valid`=1 for one cycle.
    - Otherwise: `frame_err`=1 for one cycle and `adc_data` holds its previous value.
  - QUIET: 2D cycles with `adc_cs_n` high, then → IDLE.
- Latency from tick to `adc_valid` is 34D+1 cycles (171 at D=5). The full frame including QUIET is 36D+1 cycles.
- If `SAMPLE_PERIOD` < 36D+1, every other tick sets `overrun`. This is legal and the block does not lock up.
- `overrun` is sticky: set by a busy tick, cleared by `overrun_clr`. If both occur in the same cycle, set wins.
- `enable` deasserted mid-frame: the current frame completes and produces `adc_valid` or `frame_err` as normal. No new frame starts.
- `rst` mid-frame: on the next edge, all outputs return to their reset values, no strobe is issued, and the partial frame is discarded.
- At most one of `adc_valid`/`frame_err` is high per frame, and neither is ever high for more than one cycle.

Optional Feature:
- Macro: `ADC_AVG_EN`.
- Defined:
  - Accepted samples accumulate in a 14-bit sum. Frames that raise `frame_err` are not counted.
  - Every 4th accepted frame: `adc_data` ← sum[13:2] (truncate), `adc_valid` pulses, and the sum and count clear.
  - The strobe occurs on the same edge as the 4th frame's `adc_cs_n` rise.
  - Reset clears the sum and count.
- Undefined: every accepted frame updates `adc_data` directly. No accumulator logic is present.

Test Plan:
- D=5, `SAMPLE_PERIOD`=200, ADC model returns 0x0708:
  - Exactly 16 `adc_sclk` rising edges, `adc_cs_n` low for 170 cycles.
  - `adc_valid` one cycle, 171 cycles after the tick, with `adc_data`=1800.
  - Next `adc_cs_n` fall is 200 cycles after the previous one.
- ADC model returns 0x8800 after a good 1800 frame:
  - `frame_err` pulses once and there is no `adc_valid`.
  - `adc_data` stays at 1800.
- `SAMPLE_PERIOD`=150 (below 181):
  - `overrun` sets on the 2nd tick and frames occur every 300 cycles.
  - Pulsing `overrun_clr` clears it, and it sets again on the next busy tick.
  - Driving `overrun_clr` in the same cycle as a busy tick leaves `overrun`=1.
- `rst` asserted during the 8th SCLK period:
  - Next cycle `adc_cs_n`=1, `adc_sclk`=1, `busy`=0, and no strobe is issued.
  - After release, the next tick produces a clean frame returning 2048.
- `enable` dropped during SHIFT:
  - The frame completes with `adc_valid`/`adc_data`=2200.
  - No further `adc_cs_n` falls for 5 sample periods.
  - Re-asserting `enable` resumes frames on the next tick.
- With `ADC_AVG_EN`, samples 2040, 2044, 0x8000-frame, 2048, 2060:
  - `frame_err` pulses once.
  - A single `adc_valid` occurs after the 5th frame, with `adc_data`=2048.
